// File: rtl/dlc_pipe_elastic_if.sv
// Upstream/downstream handshake bundle for the elastic pipeline.
// slave is the pipeline side; master is the traffic source/sink side.
interface dlc_pipe_elastic_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dlc_pipe_elastic.sv
// Elastic valid/ready register pipeline with bubble collapse, global enable,
// flush and occupancy count.
module dlc_pipe_elastic #(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] RSTV  = '0,
  localparam int              CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  dlc_pipe_elastic_if.slave bus,
  output logic [CNT_W-1:0]  occupancy
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] ld;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic             adv;

  assign adv = enable & ~flush;

  // ld[i] unrolls to: any hole at or downstream of stage i, or the sink pops.
  // Walking from the output side keeps the chain free of combinational loops.
  always_comb begin : ld_chain
    logic hole;
    hole = bus.out_ready;
    ld   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hole  = hole | ~v_q[i];
      ld[i] = adv & hole;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;

    if (gi == 0) begin : g_head
      assign src_v = bus.in_valid;
      assign src_d = bus.in_data;
    end else begin : g_body
      assign src_v = v_q[gi-1];
      assign src_d = d_q[gi-1];
    end

    // Data only moves with a valid source so idle-bus X never enters a stage.
    assign v_d[gi] = ld[gi] ? src_v : v_q[gi];
    assign d_d[gi] = (ld[gi] && src_v) ? src_d : d_q[gi];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= RSTV;
      end
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + CNT_W'(v_q[i]);
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = v_q[DEPTH-1] & ~flush;
  assign bus.out_data  = d_q[DEPTH-1];

endmodule

// File: tb/tb_dlc_pipe_elastic.sv
// Scoreboard bench: a DEPTH=3 and a DEPTH=4 pipeline share clk/reset/enable/flush;
// accepted beats are queued and compared in order when each pipeline emits them.
module tb_dlc_pipe_elastic;

  localparam logic [7:0] RV = 8'h5A;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] occ3;
  logic [2:0] occ4;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q3[$];
  logic [7:0] q4[$];

  dlc_pipe_elastic_if #(.WIDTH(8)) bus3 ();
  dlc_pipe_elastic_if #(.WIDTH(8)) bus4 ();

  dlc_pipe_elastic #(.WIDTH(8), .DEPTH(3), .RSTV(RV)) u3 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .bus(bus3), .occupancy(occ3)
  );

  dlc_pipe_elastic #(.WIDTH(8), .DEPTH(4), .RSTV(RV)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .bus(bus4), .occupancy(occ4)
  );

  always #5 clk = ~clk;

  // Scoreboard monitors: decide at the negedge what the next posedge will transfer.
  always @(negedge clk) begin
    logic [7:0] exp3;
    if (reset || flush) begin
      q3.delete();
    end else begin
      if (bus3.out_valid && bus3.out_ready && enable) begin
        n_cmp++;
        if (q3.size() == 0) begin
          n_err++;
          $display("FAIL sb3_unexpected: got out_data=%02h, expected no beat", bus3.out_data);
        end else begin
          exp3 = q3.pop_front();
          if (bus3.out_data !== exp3) begin
            n_err++;
            $display("FAIL sb3_data: got %02h, expected %02h", bus3.out_data, exp3);
          end else begin
            $display("d3 out %02h", bus3.out_data);
          end
        end
      end
      if (bus3.in_valid && bus3.in_ready) q3.push_back(bus3.in_data);
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp4;
    if (reset || flush) begin
      q4.delete();
    end else begin
      if (bus4.out_valid && bus4.out_ready && enable) begin
        n_cmp++;
        if (q4.size() == 0) begin
          n_err++;
          $display("FAIL sb4_unexpected: got out_data=%02h, expected no beat", bus4.out_data);
        end else begin
          exp4 = q4.pop_front();
          if (bus4.out_data !== exp4) begin
            n_err++;
            $display("FAIL sb4_data: got %02h, expected %02h", bus4.out_data, exp4);
          end else begin
            $display("d4 out %02h", bus4.out_data);
          end
        end
      end
      if (bus4.in_valid && bus4.in_ready) q4.push_back(bus4.in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; flush = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_data = 8'hxx; bus3.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_data = 8'hxx; bus4.out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus3.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid3: got %b, expected 0", bus3.out_valid); end
    n_cmp++; if (bus3.out_data !== RV) begin n_err++; $display("FAIL rst_out_data3: got %02h, expected %02h", bus3.out_data, RV); end
    n_cmp++; if (occ3 !== 2'd0) begin n_err++; $display("FAIL rst_occ3: got %0d, expected 0", occ3); end
    n_cmp++; if (bus3.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready3: got %b, expected 1", bus3.in_ready); end
    n_cmp++; if (occ4 !== 3'd0 || bus4.out_data !== RV) begin n_err++; $display("FAIL rst_state4: got occ=%0d data=%02h, expected 0/%02h", occ4, bus4.out_data, RV); end
    enable = 1'b0;
    #1;
    n_cmp++; if (bus3.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready_dis: got %b, expected 0", bus3.in_ready); end
    enable = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_streaming();
    bus3.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus3.in_valid = (i < 10);
      bus3.in_data  = (i < 10) ? 8'(i + 1) : 8'hxx;
      @(negedge clk);
      if (i < 10) begin
        n_cmp++; if (bus3.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b, expected 1", i, bus3.in_ready); end
      end
      n_cmp++;
      if (bus3.out_valid !== (i >= 3 && i <= 12)) begin
        n_err++; $display("FAIL stream_out_valid[%0d]: got %b, expected %b", i, bus3.out_valid, (i >= 3 && i <= 12));
      end
      step();
    end
    bus3.in_valid = 1'b0;
    n_cmp++; if (q3.size() != 0) begin n_err++; $display("FAIL stream_drain: got %0d left, expected 0", q3.size()); end
    $display("test_streaming done");
  endtask

  task automatic test_backpressure();
    int acc = 0;
    bus3.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus3.in_valid = 1'b1;
      bus3.in_data  = 8'(8'h11 + acc);
      @(negedge clk);
      if (bus3.in_ready) acc++;
      step();
    end
    n_cmp++; if (acc != 3) begin n_err++; $display("FAIL bp_accepted: got %0d, expected 3", acc); end
    @(negedge clk);
    n_cmp++; if (occ3 !== 2'd3) begin n_err++; $display("FAIL bp_occ: got %0d, expected 3", occ3); end
    n_cmp++; if (bus3.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b, expected 0", bus3.in_ready); end
    n_cmp++; if (bus3.out_valid !== 1'b1 || bus3.out_data !== 8'h11) begin n_err++; $display("FAIL bp_head: got v=%b d=%02h, expected 1/11", bus3.out_valid, bus3.out_data); end
    step();
    bus3.out_ready = 1'b1;
    for (int k = 0; k < 10 && acc < 5; k++) begin
      bus3.in_valid = 1'b1;
      bus3.in_data  = 8'(8'h11 + acc);
      @(negedge clk);
      if (bus3.in_ready) acc++;
      step();
    end
    bus3.in_valid = 1'b0;
    n_cmp++; if (acc != 5) begin n_err++; $display("FAIL bp_accept_all: got %0d, expected 5", acc); end
    for (int k = 0; k < 30 && q3.size() != 0; k++) step();
    n_cmp++; if (q3.size() != 0 || occ3 !== 2'd0) begin n_err++; $display("FAIL bp_drain: got %0d left occ=%0d, expected 0/0", q3.size(), occ3); end
    $display("test_backpressure done");
  endtask

  task automatic test_bubble_collapse();
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.in_data   = 8'h21;
    @(negedge clk);
    n_cmp++; if (bus4.in_ready !== 1'b1) begin n_err++; $display("FAIL bub_first_accept: got %b, expected 1", bus4.in_ready); end
    step();
    bus4.in_valid = 1'b0;
    bus4.in_data  = 8'hxx;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      n_cmp++; if (bus4.out_valid !== (j == 4)) begin n_err++; $display("FAIL bub_latency[%0d]: got %b, expected %b", j, bus4.out_valid, (j == 4)); end
      if (j < 4) step();
    end
    step();
    for (int j = 0; j < 3; j++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 8'(8'h22 + j);
      @(negedge clk);
      n_cmp++; if (bus4.in_ready !== 1'b1) begin n_err++; $display("FAIL bub_accept[%0d]: got %b, expected 1", j, bus4.in_ready); end
      step();
    end
    bus4.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (occ4 !== 3'd4 || bus4.in_ready !== 1'b1) begin
      // in_valid is low but a full pipe with out_ready low must refuse
      if (!(occ4 === 3'd4 && bus4.in_ready === 1'b0)) begin
        n_err++; $display("FAIL bub_full: got occ=%0d rdy=%b, expected 4/0", occ4, bus4.in_ready);
      end
    end
    step();
    bus4.out_ready = 1'b1;
    for (int k = 0; k < 30 && q4.size() != 0; k++) step();
    n_cmp++; if (q4.size() != 0) begin n_err++; $display("FAIL bub_drain: got %0d left, expected 0", q4.size()); end
    $display("test_bubble_collapse done");
  endtask

  task automatic test_enable_freeze();
    bus3.out_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      bus3.in_valid = 1'b1;
      bus3.in_data  = 8'(8'h31 + j);
      @(negedge clk);
      n_cmp++; if (bus3.in_ready !== 1'b1) begin n_err++; $display("FAIL frz_fill[%0d]: got %b, expected 1", j, bus3.in_ready); end
      step();
    end
    bus3.in_valid = 1'b0;
    step(); step();
    enable = 1'b0;
    bus3.out_ready = 1'b1;
    bus3.in_valid  = 1'b1;
    bus3.in_data   = 8'h99;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      n_cmp++;
      if (bus3.in_ready !== 1'b0 || occ3 !== 2'd2 || bus3.out_valid !== 1'b1 || bus3.out_data !== 8'h31) begin
        n_err++;
        $display("FAIL frz_hold[%0d]: got rdy=%b occ=%0d v=%b d=%02h, expected 0/2/1/31",
                 j, bus3.in_ready, occ3, bus3.out_valid, bus3.out_data);
      end
      step();
    end
    enable = 1'b1;
    bus3.in_valid = 1'b0;
    for (int k = 0; k < 30 && q3.size() != 0; k++) step();
    n_cmp++; if (q3.size() != 0 || occ3 !== 2'd0) begin n_err++; $display("FAIL frz_drain: got %0d left occ=%0d, expected 0/0", q3.size(), occ3); end
    $display("test_enable_freeze done");
  endtask

  task automatic test_flush_reset();
    for (int pass = 0; pass < 2; pass++) begin
      bus3.out_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
        bus3.in_valid = 1'b1;
        bus3.in_data  = 8'(8'h41 + 16 * pass + j);
        step();
      end
      bus3.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (occ3 !== 2'd3) begin n_err++; $display("FAIL fr_fill[%0d]: got occ=%0d, expected 3", pass, occ3); end
      step();
      bus3.in_valid  = 1'b1;
      bus3.in_data   = 8'hEE;
      bus3.out_ready = 1'b1;
      if (pass == 0) begin
        flush = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus3.in_ready !== 1'b0 || bus3.out_valid !== 1'b0) begin
          n_err++; $display("FAIL fr_flush_cycle: got rdy=%b v=%b, expected 0/0", bus3.in_ready, bus3.out_valid);
        end
      end else begin
        reset  = 1'b1;
        enable = 1'b0;
      end
      step();
      flush = 1'b0; reset = 1'b0; enable = 1'b1;
      bus3.in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (occ3 !== 2'd0 || bus3.out_data !== RV || bus3.out_valid !== 1'b0) begin
        n_err++; $display("FAIL fr_cleared[%0d]: got occ=%0d d=%02h v=%b, expected 0/%02h/0", pass, occ3, bus3.out_data, bus3.out_valid, RV);
      end
      step();
    end
    $display("test_flush_reset done");
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_enable_freeze();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dlc_pipe_elastic.md
DLC_PIPE_ELASTIC -- requirements
Module: dlc_pipe_elastic

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per beat (1..512).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (1..16).
REQ-003 SHALL have parameter RSTV, default 0, WIDTH-bit value loaded into every stage data register on reset or flush.
REQ-004 SHALL have local parameter CNT_W = $clog2(DEPTH+1).
REQ-005 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1, global advance enable; low freezes all state.
REQ-008 SHALL have port flush, input, 1, synchronous discard of all held beats.
REQ-009 SHALL have port in_valid, input, 1, upstream beat present.
REQ-010 SHALL have port in_ready, output, 1, block accepts beat this cycle.
REQ-011 SHALL have port in_data, input, WIDTH, upstream beat data.
REQ-012 SHALL have port out_valid, output, 1, beat present at stage DEPTH-1.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts beat.
REQ-014 SHALL have port out_data, output, WIDTH, data of stage DEPTH-1.
REQ-015 SHALL have port occupancy, output, CNT_W, number of valid stages.

Function
REQ-016 SHALL hold per stage i (0 = input side, DEPTH-1 = output side) a valid bit v[i] and data register d[i].
REQ-017 SHALL define ld[i] = enable & ~flush & (~v[i] | pop[i]), with pop[DEPTH-1] = out_ready and pop[i] = ld[i+1] otherwise.
REQ-018 SHALL drive in_ready = ld[0] and out_valid = v[DEPTH-1] & ~flush, out_data = d[DEPTH-1].
REQ-019 SHALL, when ld[i], load v[i] from v[i-1] (in_valid for i=0), and load d[i] from d[i-1] (in_data for i=0) only when the source is valid; d[i] holds otherwise.
REQ-020 SHALL, when ~ld[i], hold v[i] and d[i] unchanged.
REQ-021 SHALL count an input transfer only when in_valid & in_ready, and an output transfer only when out_valid & out_ready & enable.
REQ-022 SHALL give latency exactly DEPTH cycles from input transfer to out_valid with no stalls, and sustain 1 beat/cycle throughput.
REQ-023 SHALL collapse bubbles: an empty stage loads from upstream even while the output stage is stalled.
REQ-024 SHALL hold up to DEPTH beats, preserve order, never drop or duplicate a beat.
REQ-025 SHALL, when full and out_ready & enable, accept a new input in the same cycle (simultaneous push/pop).
REQ-026 SHALL, with enable low, force in_ready low, freeze all v/d, keep out_valid/out_data stable, and ignore out_ready.
REQ-027 SHALL, on flush high (enable irrelevant), clear all v[i], load all d[i] with RSTV, force in_ready and out_valid low that cycle; input beat that cycle is discarded.
REQ-028 SHALL drive occupancy as the combinational popcount of v[0..DEPTH-1].
REQ-029 SHALL never sample in_data when in_valid is low; X on in_data with in_valid low SHALL not propagate.
REQ-030 SHALL, for DEPTH=1, reduce to in_ready = enable & ~flush & (~v[0] | out_ready).

Reset
REQ-031 SHALL, on reset high at a rising edge, clear all v[i] and load all d[i] with RSTV regardless of enable and flush.
REQ-032 SHALL present after reset: out_valid=0, out_data=RSTV, occupancy=0, in_ready=enable & ~flush.
REQ-033 SHALL discard all in-flight beats when reset asserts mid-operation; no beat transfers in a reset cycle.

Verification
REQ-034 SHALL cover streaming: DEPTH=3, enable=1, out_ready=1, push 0x01..0x0A back-to-back -> 0x01 out_valid 3 cycles after first accept, then one beat/cycle in order.
REQ-035 SHALL cover backpressure: DEPTH=3, out_ready=0, push 5 beats -> 3 accepted, occupancy=3, in_ready=0; raise out_ready -> all 3 out in order, 4th/5th follow.
REQ-036 SHALL cover bubble collapse: DEPTH=4, one beat pushed, out_ready=0 -> beat at stage 3 after 4 cycles; next 3 pushes accepted consecutively, occupancy reaches 4.
REQ-037 SHALL cover enable freeze: occupancy=2, enable=0 for 5 cycles with out_ready=1, in_valid=1 -> no transfers, outputs stable, occupancy stays 2.
REQ-038 SHALL cover flush and reset: full pipeline, flush=1 one cycle -> next cycle occupancy=0, out_data=RSTV; repeat with reset=1, enable=0 -> same result.
